dbg_cmd_deframer: RTL and testbench
===================================

# dbg_cmd_deframer

Byte-stream command deframer between the host UART receiver and the nX-u8 debug transaction engine. It consumes the received byte stream through a valid/ready handshake and parses the frames `'r' <reg>` and `'w' <reg> <hi> <lo>`. Each complete frame is presented as one parallel command word on a valid/ready handshake. It also reports malformed, stalled and (optionally) corrupted frames, so the control FSM never sees a partial command.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000000: maximum idle gap between bytes inside a frame, in `clk` cycles. 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `s_tdata`  in  8  received byte.
- `s_tvalid`  in  1  byte valid.
- `s_tready`  out  1  deframer accepts the byte this cycle.
- `cmd_dir`  out  1  1 = read (`'r'`), 0 = write (`'w'`).
- `cmd_reg`  out  7  debug register: bits [6:0] of the register byte. Bit 7 is ignored.
- `cmd_wdata`  out  16  write value, high byte first on the wire. 0 for reads.
- `cmd_valid`  out  1  command word valid.
- `cmd_ready`  in  1  consumer accepts the command.
- `err_pulse`  out  1  one-cycle strobe when a frame is aborted.
- `err_code`  out  2  cause of the last abort: 1 = bad command byte, 2 = timeout, 3 = checksum. Holds its value until the next abort.
- `frame_cnt`  out  8  number of commands handed off. Wraps from 255 to 0.

## Operation
- Byte acceptance: a byte is accepted on any edge where `s_tvalid && s_tready`.
- States: IDLE, REG, VAL_HI, VAL_LO, CSUM (only with the macro), HOLD.
- IDLE:
  - 0x72 → `cmd_dir`=1, go to REG.
  - 0x77 → `cmd_dir`=0, go to REG.
  - Any other byte is consumed, raises an abort with code 1, and the FSM stays in IDLE.
- REG: latch `cmd_reg`.
  - Read → CSUM if enabled, else HOLD. `cmd_wdata` is cleared to 0.
  - Write → VAL_HI.
- VAL_HI: latch `cmd_wdata[15:8]`, go to VAL_LO.
- VAL_LO: latch `cmd_wdata[7:0]`, go to CSUM if enabled, else HOLD.
- HOLD: `cmd_valid`=1 and `s_tready`=0.
  - On `cmd_valid && cmd_ready`: increment `frame_cnt` and go to IDLE.
- `s_tready` is 1 in every state except HOLD.
- Timeout:
  - A gap counter runs in REG, VAL_HI, VAL_LO and CSUM. It clears on every accepted byte and on entry to IDLE.
  - When the counter reaches `TIMEOUT_CYCLES`: abort with code 2 and go to IDLE.
  - The counter does not run in IDLE or HOLD. HOLD waits for `cmd_ready` indefinitely.
- Abort sequence: `err_pulse`=1 for exactly one cycle, `err_code` is updated, and partial fields are discarded (`cmd_valid` never rises for that frame).
- Reset values: `s_tready`=0 while `rst_n` is low, then 1 from the first edge after release (IDLE). All other outputs reset to 0.
- Reset asserted mid-frame or in HOLD discards everything immediately. `frame_cnt` also returns to 0.

## Timing
- `cmd_valid` rises on the edge that accepts the final byte of the frame. Back-to-back bytes (one per cycle) are supported with no bubbles.
- `cmd_dir`, `cmd_reg` and `cmd_wdata` are stable for the whole time `cmd_valid` is high.
- `cmd_valid` falls on the edge where the handshake completes. `s_tready` rises on that same edge, so the next frame's first byte can be accepted on the following edge.
- `frame_cnt` updates on the handshake edge.
- `err_pulse` is registered and asserted on the same edge as the transition to IDLE.
- Timeout expiry and byte acceptance on the same edge: the byte wins, the counter clears and there is no abort.

## Configuration
- `DBG_CMD_CSUM_EN`:
  - Defined: every frame carries a trailing checksum byte equal to the XOR of all preceding frame bytes. The CSUM state compares it against a running XOR.
    - Match → HOLD.
    - Mismatch → abort with code 3 and discard the frame.
  - Undefined: no CSUM state, no checksum logic. Error code 3 is never produced.

## Test plan
- Read frame 0x72,0x05 → `cmd_valid`=1 with `cmd_dir`=1, `cmd_reg`=0x05, `cmd_wdata`=0x0000. Hold `cmd_ready`=0 for 10 cycles: fields stable and `s_tready`=0. Raise `cmd_ready`: `frame_cnt` goes 0→1.
- Write frame 0x77,0x12,0xAB,0xCD at one byte per cycle → `cmd_dir`=0, `cmd_reg`=0x12, `cmd_wdata`=0xABCD, with `cmd_valid` high on the edge accepting 0xCD.
- Byte 0x41 in IDLE → `err_pulse` for one cycle, `err_code`=1, no `cmd_valid`. A following 0x72,0x01 then parses normally.
- With `TIMEOUT_CYCLES`=16, send 0x77,0x12 and then stop → abort with `err_code`=2 exactly 16 cycles after 0x12 is accepted.
- With `DBG_CMD_CSUM_EN` defined:
  - 0x77,0x12,0xAB,0xCD,0x03 → command accepted.
  - Same frame with checksum 0x04 → `err_code`=3, no command.
  - Read frame 0x72,0x05,0x77 → command accepted.
- Assert `rst_n` low while in VAL_LO, and again in HOLD with `frame_cnt`=5 → all outputs return to reset values and `frame_cnt`=0. The next full frame parses correctly.

Source files
------------

// File: rtl/dbg_cmd_deframer.sv
// -----------------------------------------------------------------------------
// dbg_cmd_deframer
//
// Parses the host UART byte stream into debug commands for the nX-u8 debug
// transaction engine. Accepted frames:
//   'r' (0x72) <reg>             -> read command
//   'w' (0x77) <reg> <hi> <lo>   -> write command
// Every complete frame is presented as one parallel command word held on a
// valid/ready handshake. Bad command bytes, inter-byte stalls and (optionally)
// checksum mismatches abort the frame, so the consumer never sees a partial
// command.
//
// Optional feature macro: DBG_CMD_CSUM_EN
//   When defined, each frame carries a trailing byte equal to the XOR of all
//   preceding frame bytes, and a mismatch aborts the frame with code 3.
//
// Parameters:
//   TIMEOUT_CYCLES  max idle gap between bytes inside a frame (0 = disabled)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   s_tdata    in   [7:0]  received byte
//   s_tvalid   in   byte valid
//   s_tready   out  byte accepted this cycle (low in reset and while holding)
//   cmd_dir    out  1 = read, 0 = write
//   cmd_reg    out  [6:0]  debug register number
//   cmd_wdata  out  [15:0] write value (0 for reads)
//   cmd_valid  out  command word valid
//   cmd_ready  in   consumer accepts the command
//   err_pulse  out  one-cycle strobe on frame abort
//   err_code   out  [1:0]  cause of last abort: 1 bad cmd, 2 timeout, 3 csum
//   frame_cnt  out  [7:0]  commands handed off, wrapping
// -----------------------------------------------------------------------------
module dbg_cmd_deframer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic        cmd_dir,
    output logic [6:0]  cmd_reg,
    output logic [15:0] cmd_wdata,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REG    = 3'd1,
        ST_VAL_HI = 3'd2,
        ST_VAL_LO = 3'd3,
`ifdef DBG_CMD_CSUM_EN
        ST_CSUM   = 3'd4,
`endif
        ST_HOLD   = 3'd5
    } state_t;

    localparam logic [7:0] CMD_READ    = 8'h72;
    localparam logic [7:0] CMD_WRITE   = 8'h77;
    localparam logic [1:0] ERR_BAD_CMD = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
`ifdef DBG_CMD_CSUM_EN
    localparam logic [1:0] ERR_CSUM    = 2'd3;
    // After the last payload byte the frame still owes its checksum.
    localparam state_t     ST_AFTER_DATA = ST_CSUM;
`else
    localparam state_t     ST_AFTER_DATA = ST_HOLD;
`endif

    localparam int           GAP_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(TIMEOUT_CYCLES);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_run;
    logic               r_dir;
    logic [6:0]         r_reg;
    logic [15:0]        r_wdata;
    logic               r_err_pulse;
    logic [1:0]         r_err_code;
    logic [7:0]         r_frame_cnt;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   w_gap_inc;
    logic               w_accept;
    logic               w_handoff;
    logic               w_gap_run;
    logic               w_timeout;
    logic               w_abort;
    logic [1:0]         w_abort_code;
`ifdef DBG_CMD_CSUM_EN
    logic [7:0]         r_csum;
`endif

    // r_run holds s_tready low until the first edge after reset release.
    assign s_tready  = r_run && (r_state != ST_HOLD);
    assign cmd_valid = (r_state == ST_HOLD);
    assign w_accept  = s_tvalid && s_tready;
    assign w_handoff = cmd_valid && cmd_ready;

    assign cmd_dir   = r_dir;
    assign cmd_reg   = r_reg;
    assign cmd_wdata = r_wdata;
    assign err_pulse = r_err_pulse;
    assign err_code  = r_err_code;
    assign frame_cnt = r_frame_cnt;

    // Gap counter only runs inside a frame; an accepted byte always beats an
    // expiring counter on the same edge.
    assign w_gap_run = (r_state != ST_IDLE) && (r_state != ST_HOLD);
    assign w_gap_inc = r_gap + 1'b1;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_gap_run && !w_accept &&
                       (w_gap_inc == GAP_LIM);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and abort decode
    // -------------------------------------------------------------------------
    // NOTE: every output of this block is given a default first so that no
    // path through the case leaves one unassigned, which would infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        w_abort_code = ERR_BAD_CMD;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if ((s_tdata == CMD_READ) || (s_tdata == CMD_WRITE)) begin
                        w_state_next = ST_REG;
                    end else begin
                        w_abort = 1'b1;
                    end
                end
            end
            ST_REG: begin
                if (w_accept) begin
                    w_state_next = r_dir ? ST_AFTER_DATA : ST_VAL_HI;
                end
            end
            ST_VAL_HI: begin
                if (w_accept) begin
                    w_state_next = ST_VAL_LO;
                end
            end
            ST_VAL_LO: begin
                if (w_accept) begin
                    w_state_next = ST_AFTER_DATA;
                end
            end
`ifdef DBG_CMD_CSUM_EN
            ST_CSUM: begin
                if (w_accept) begin
                    if (s_tdata == r_csum) begin
                        w_state_next = ST_HOLD;
                    end else begin
                        w_abort      = 1'b1;
                        w_abort_code = ERR_CSUM;
                        w_state_next = ST_IDLE;
                    end
                end
            end
`endif
            ST_HOLD: begin
                if (w_handoff) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // w_timeout already excludes edges with an accepted byte.
        if (w_timeout) begin
            w_abort      = 1'b1;
            w_abort_code = ERR_TIMEOUT;
            w_state_next = ST_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Field capture, status and counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_dir       <= 1'b0;
            r_reg       <= 7'd0;
            r_wdata     <= 16'd0;
            r_err_pulse <= 1'b0;
            r_err_code  <= 2'd0;
            r_frame_cnt <= 8'd0;
            r_gap       <= '0;
`ifdef DBG_CMD_CSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_run       <= 1'b1;
            r_err_pulse <= w_abort;

            if (w_abort) begin
                r_err_code <= w_abort_code;
            end

            if (w_handoff) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end

            if (!w_gap_run || w_accept || w_timeout) begin
                r_gap <= '0;
            end else begin
                r_gap <= w_gap_inc;
            end

            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_state_next == ST_REG) begin
                            r_dir <= (s_tdata == CMD_READ);
                        end
                    end
                    ST_REG: begin
                        r_reg <= s_tdata[6:0];
                        if (r_dir) begin
                            r_wdata <= 16'd0;
                        end
                    end
                    ST_VAL_HI: r_wdata[15:8] <= s_tdata;
                    ST_VAL_LO: r_wdata[7:0]  <= s_tdata;
                    default: ;
                endcase
`ifdef DBG_CMD_CSUM_EN
                // Running XOR restarts with the command byte of each frame.
                r_csum <= (r_state == ST_IDLE) ? s_tdata : (r_csum ^ s_tdata);
`endif
            end
        end
    end

endmodule

// File: tb/tb_dbg_cmd_deframer.sv
// -----------------------------------------------------------------------------
// tb_dbg_cmd_deframer
//
// Directed bench for dbg_cmd_deframer with TIMEOUT_CYCLES = 16. Inputs are
// driven on the falling edge, outputs sampled 1 ns after the rising edge.
// Frames carry a trailing checksum byte only when DBG_CMD_CSUM_EN is defined.
// -----------------------------------------------------------------------------
`ifdef DBG_CMD_CSUM_EN
`define SEND_CSUM(c) send_byte(c)
`else
`define SEND_CSUM(c)
`endif

module tb_dbg_cmd_deframer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        cmd_dir;
    logic [6:0]  cmd_reg;
    logic [15:0] cmd_wdata;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    dbg_cmd_deframer #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .cmd_dir   (cmd_dir),
        .cmd_reg   (cmd_reg),
        .cmd_wdata (cmd_wdata),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        s_tdata  = b;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tready"}, 32'(s_tready),  0);
        check({tag, "_valid"},  32'(cmd_valid), 0);
        check({tag, "_dir"},    32'(cmd_dir),   0);
        check({tag, "_reg"},    32'(cmd_reg),   0);
        check({tag, "_wdata"},  32'(cmd_wdata), 0);
        check({tag, "_epulse"}, 32'(err_pulse), 0);
        check({tag, "_ecode"},  32'(err_code),  0);
        check({tag, "_cnt"},    32'(frame_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        s_tdata   = 8'h00;
        s_tvalid  = 1'b0;
        cmd_ready = 1'b0;

        // ---- reset state, with the clock running ----
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_tready", 32'(s_tready), 1);

        // ---- read frame, held by consumer for 10 cycles ----
        send_byte(8'h72);
        check("rd_mid_valid", 32'(cmd_valid), 0);
        send_byte(8'h05);
        `SEND_CSUM(8'h77);
        check("rd_valid", 32'(cmd_valid), 1);
        check("rd_dir",   32'(cmd_dir),   1);
        check("rd_reg",   32'(cmd_reg),   'h05);
        check("rd_wdata", 32'(cmd_wdata), 'h0000);
        check("rd_tready", 32'(s_tready), 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("rd_hold_valid",  32'(cmd_valid), 1);
            check("rd_hold_reg",    32'(cmd_reg),   'h05);
            check("rd_hold_tready", 32'(s_tready),  0);
        end
        check("rd_cnt_before", 32'(frame_cnt), 0);
        handshake();
        check("rd_hs_valid",  32'(cmd_valid), 0);
        check("rd_hs_tready", 32'(s_tready),  1);
        check("rd_hs_cnt",    32'(frame_cnt), 1);

        // ---- write frame, back-to-back bytes ----
        send_byte(8'h77);
        send_byte(8'h12);
        send_byte(8'hAB);
        check("wr_mid_valid", 32'(cmd_valid), 0);
        send_byte(8'hCD);
        `SEND_CSUM(8'h03);
        check("wr_valid", 32'(cmd_valid), 1);
        check("wr_dir",   32'(cmd_dir),   0);
        check("wr_reg",   32'(cmd_reg),   'h12);
        check("wr_wdata", 32'(cmd_wdata), 'hABCD);
        handshake();
        check("wr_cnt", 32'(frame_cnt), 2);

        // ---- bad command byte in IDLE ----
        send_byte(8'h41);
        check("bad_pulse", 32'(err_pulse), 1);
        check("bad_code",  32'(err_code),  1);
        check("bad_valid", 32'(cmd_valid), 0);
        @(posedge clk);
        #1;
        check("bad_pulse_off", 32'(err_pulse), 0);
        check("bad_code_hold", 32'(err_code),  1);
        send_byte(8'h72);
        send_byte(8'h01);
        `SEND_CSUM(8'h73);
        check("rec_valid", 32'(cmd_valid), 1);
        check("rec_dir",   32'(cmd_dir),   1);
        check("rec_reg",   32'(cmd_reg),   'h01);
        handshake();
        check("rec_cnt", 32'(frame_cnt), 3);

        // ---- register byte bit 7 ignored ----
        send_byte(8'h72);
        send_byte(8'h85);
        `SEND_CSUM(8'hF7);
        check("b7_valid", 32'(cmd_valid), 1);
        check("b7_reg",   32'(cmd_reg),   'h05);
        handshake();
        check("b7_cnt", 32'(frame_cnt), 4);

        // ---- timeout: abort exactly 16 cycles after 0x12 ----
        send_byte(8'h77);
        send_byte(8'h12);
        for (int i = 1; i < 16; i++) begin
            @(posedge clk);
            #1;
            check("to_early_pulse", 32'(err_pulse), 0);
        end
        @(posedge clk);
        #1;
        check("to_pulse", 32'(err_pulse), 1);
        check("to_code",  32'(err_code),  2);
        check("to_valid", 32'(cmd_valid), 0);
        @(posedge clk);
        #1;
        check("to_pulse_off", 32'(err_pulse), 0);

        // ---- byte arriving on the expiry edge wins ----
        send_byte(8'h77);
        repeat (15) @(posedge clk);
        send_byte(8'h12);
        check("win_pulse", 32'(err_pulse), 0);
        send_byte(8'hAB);
        send_byte(8'hCD);
        `SEND_CSUM(8'h03);
        check("win_valid", 32'(cmd_valid), 1);
        check("win_wdata", 32'(cmd_wdata), 'hABCD);
        check("win_code",  32'(err_code),  2);
        handshake();
        check("win_cnt", 32'(frame_cnt), 5);

`ifdef DBG_CMD_CSUM_EN
        // ---- checksum mismatch ----
        send_byte(8'h77);
        send_byte(8'h12);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h04);
        check("cs_pulse", 32'(err_pulse), 1);
        check("cs_code",  32'(err_code),  3);
        check("cs_valid", 32'(cmd_valid), 0);
        check("cs_cnt",   32'(frame_cnt), 5);
`endif

        // ---- HOLD waits past the timeout, then reset with frame_cnt = 5 ----
        send_byte(8'h72);
        send_byte(8'h05);
        `SEND_CSUM(8'h77);
        repeat (20) @(posedge clk);
        #1;
        check("hold_long_valid", 32'(cmd_valid), 1);
        check("hold_long_pulse", 32'(err_pulse), 0);
        check("hold_long_cnt",   32'(frame_cnt), 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel2_tready", 32'(s_tready), 1);

        // ---- reset while in VAL_LO ----
        send_byte(8'h77);
        send_byte(8'h12);
        send_byte(8'hAB);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_vallo");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- full frame after reset ----
        send_byte(8'h77);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        `SEND_CSUM(8'h6D);
        check("post_valid", 32'(cmd_valid), 1);
        check("post_dir",   32'(cmd_dir),   0);
        check("post_reg",   32'(cmd_reg),   'h34);
        check("post_wdata", 32'(cmd_wdata), 'h5678);
        handshake();
        check("post_cnt", 32'(frame_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
